// File: rtl/regfile_param.sv
// Parametrised CPU register file with N_RD combinational read ports, one write port and a busy scoreboard.
// Reads take 0 cycles and writes take 1 cycle; there is no backpressure, so every write and issue is accepted.
module regfile_param #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int N_RD     = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [N_RD*ADDR_W-1:0]     rd_addr,
   output logic [N_RD*DATA_W-1:0]     rd_data,
   output logic [N_RD-1:0]            rd_busy,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   output logic [(1<<ADDR_W)-1:0]     busy_vec
);

   localparam int NREGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(NREGS - 1);

   if (N_RD < 1 || N_RD > 4) begin : g_bad_nrd
      $error("regfile_param: N_RD must be in 1..4");
   end

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy_q;
   logic              wr_ok;
   logic              iss_ok;

   // The zero register never stores data and never becomes busy.
   assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ZADDR));
   assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == ZADDR));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Issue takes priority over a same-cycle write: the write retires the
   // older instruction while the newly issued one is still outstanding.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (iss_ok && (iss_addr == ADDR_W'(i))) begin
               busy_q[i] <= 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   assign busy_vec = busy_q;

   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              is_zero;
      logic              hit;

      assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
      assign is_zero = (ZERO_REG != 0) && (addr == ZADDR);
      assign hit     = (BYPASS != 0) && wr_en && !reset && (addr == wr_addr);

      assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 : (hit ? wr_data : regs[addr]);
      assign rd_busy[k] = !is_zero && !hit && busy_q[addr];
   end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven in lockstep against an array-based reference model.
module tb_regfile_param;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         wr_en = 1'b0;
   logic         iss_en = 1'b0;
   logic [4:0]   wr_addr = '0;
   logic [4:0]   iss_addr = '0;
   logic [63:0]  wr_data = '0;
   logic [9:0]   rd_addr = '0;

   logic [127:0] d0, d2;
   logic [63:0]  d1;
   logic [1:0]   rb0, rb1, rb2;
   logic [31:0]  bv0, bv1, bv2;

   int tests = 0;
   int fails = 0;

   // Inst 0/2 share zero-register state; inst 1 has no zero register and is 32 bits wide.
   logic [63:0] m0 [32];
   logic [31:0] m1 [32];
   bit          b0 [32];
   bit          b1 [32];

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(64), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) u0 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(d0), .rd_busy(rb0),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(bv0));

   regfile_param #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(0), .BYPASS(1)) u1 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[31:0]),
      .rd_addr(rd_addr), .rd_data(d1), .rd_busy(rb1),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(bv1));

   regfile_param #(.DATA_W(64), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(0)) u2 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(d2), .rd_busy(rb2),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(bv2));

   function automatic logic [63:0] exp_data(int inst, logic [4:0] a);
      if (reset) return 64'd0;
      if (inst != 1 && a == 5'd31) return 64'd0;
      if (inst != 2 && wr_en && a == wr_addr)
         return (inst == 1) ? {32'd0, wr_data[31:0]} : wr_data;
      return (inst == 1) ? {32'd0, m1[a]} : m0[a];
   endfunction

   function automatic logic exp_busy(int inst, logic [4:0] a);
      if (reset) return 1'b0;
      if (inst != 1 && a == 5'd31) return 1'b0;
      if (inst != 2 && wr_en && a == wr_addr) return 1'b0;
      return (inst == 1) ? b1[a] : b0[a];
   endfunction

   function automatic logic [31:0] exp_vec(int inst);
      logic [31:0] v;
      v = '0;
      if (!reset) begin
         for (int i = 0; i < 32; i++) v[i] = (inst == 1) ? b1[i] : b0[i];
      end
      return v;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check(string tag);
      logic [4:0] a;
      for (int k = 0; k < 2; k++) begin
         a = rd_addr[k*5 +: 5];
         chk($sformatf("%s/d0[%0d]", tag, k), d0[k*64 +: 64], exp_data(0, a));
         chk($sformatf("%s/d1[%0d]", tag, k), {32'd0, d1[k*32 +: 32]}, exp_data(1, a));
         chk($sformatf("%s/d2[%0d]", tag, k), d2[k*64 +: 64], exp_data(2, a));
         chk($sformatf("%s/rb0[%0d]", tag, k), {63'd0, rb0[k]}, {63'd0, exp_busy(0, a)});
         chk($sformatf("%s/rb1[%0d]", tag, k), {63'd0, rb1[k]}, {63'd0, exp_busy(1, a)});
         chk($sformatf("%s/rb2[%0d]", tag, k), {63'd0, rb2[k]}, {63'd0, exp_busy(2, a)});
      end
      chk({tag, "/bv0"}, {32'd0, bv0}, {32'd0, exp_vec(0)});
      chk({tag, "/bv1"}, {32'd0, bv1}, {32'd0, exp_vec(1)});
      chk({tag, "/bv2"}, {32'd0, bv2}, {32'd0, exp_vec(2)});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m0[i] = '0; m1[i] = '0; b0[i] = 1'b0; b1[i] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            if (iss_en && iss_addr == 5'(i)) begin
               if (i != 31) b0[i] = 1'b1;
               b1[i] = 1'b1;
            end else if (wr_en && wr_addr == 5'(i)) begin
               b0[i] = 1'b0;
               b1[i] = 1'b0;
            end
         end
         if (wr_en) begin
            if (wr_addr != 5'd31) m0[wr_addr] = wr_data;
            m1[wr_addr] = wr_data[31:0];
         end
      end
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic ie, input logic [4:0] ia,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      wr_en = we; wr_addr = wa; wr_data = wd;
      iss_en = ie; iss_addr = ia;
      rd_addr = {ra1, ra0};
      #1;
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b1;
      #1 check("reset_init");
      #1 reset = 1'b0;
      tick();

      // Reset asserted mid-cycle clears data and scoreboard immediately.
      drive(1'b1, 5'd5, 64'hAC, 1'b1, 5'd9, 5'd5, 5'd5);
      check("x5_wr");
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd9);
      check("x5_after");
      #2 reset = 1'b1;
      model_reset();
      #1 check("reset_mid");
      drive(1'b1, 5'd5, 64'd77, 1'b1, 5'd5, 5'd5, 5'd5);
      tick();
      check("reset_hold");
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd5);
      #2 reset = 1'b0;
      #1 check("reset_rel");
      tick();
      check("reset_post");

      drive(1'b1, 5'd15, 64'd172, 1'b0, 5'd0, 5'd15, 5'd15);
      check("x15_n");
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd15, 5'd15);
      check("x15_n1");

      drive(1'b1, 5'd31, 64'd25, 1'b1, 5'd31, 5'd31, 5'd31);
      check("x31_wr");
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31, 5'd31);
      check("x31_after");

      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd17, 5'd17, 5'd17);
      check("sb_iss");
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd17, 5'd17);
      check("sb_n1");
      tick();
      tick();
      check("sb_n2");
      drive(1'b1, 5'd17, 64'd119, 1'b0, 5'd0, 5'd17, 5'd17);
      check("sb_wr");
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd17, 5'd17);
      check("sb_done");

      drive(1'b1, 5'd26, 64'd16, 1'b1, 5'd26, 5'd26, 5'd26);
      tick();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd26, 5'd26);
      check("collide");

      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 64'(i * 3 + 1), 1'b0, 5'd0, 5'(i), 5'd0);
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'(i), 5'(i));
         check($sformatf("sweep_alias%0d", i));
         drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
         check($sformatf("sweep_pair%0d", i));
      end

      // Random traffic, biased so reads often hit the write address.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wa;
         wa = 5'($urandom_range(31));
         drive(1'($urandom_range(1)), wa, {$urandom, $urandom},
               1'($urandom_range(3) == 0), 5'($urandom_range(31)),
               ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31)),
               ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31)));
         check($sformatf("rand%0d", n));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
